// File: rtl/microprogram_iii.sv
// Microprogrammed 8-bit accumulator CPU: 4-clock instructions sequenced by a
// 64-word control ROM indexed by {opcode, micro-step}; 16x8 register RAM preloaded on reset.
module microprogram_iii (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] IN,
    output logic [7:0] OUT
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_IN  = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned CW       = 14;
    localparam int unsigned B_MAR_PC = 0;
    localparam int unsigned B_IR_LD  = 1;
    localparam int unsigned B_PC_INC = 2;
    localparam int unsigned B_MAR_IR = 3;
    localparam int unsigned B_A_MEM  = 4;
    localparam int unsigned B_A_ADD  = 5;
    localparam int unsigned B_A_SUB  = 6;
    localparam int unsigned B_MEM_WR = 7;
    localparam int unsigned B_A_IN   = 8;
    localparam int unsigned B_OUT_LD = 9;
    localparam int unsigned B_JMP    = 10;
    localparam int unsigned B_JZ     = 11;
    localparam int unsigned B_JC     = 12;
    localparam int unsigned B_HLT    = 13;

    logic [7:0] a_q, a_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q, ir_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       halt_q, halt_d;
    logic [1:0] t_q, t_d;
    logic [7:0] out_q, out_d;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];

    logic [5:0]    uaddr;
    logic [CW-1:0] uc;
    logic [7:0]    mem_rd;
    logic [8:0]    sum;
    logic [7:0]    diff;

    function automatic logic [7:0] prog_word(input logic [3:0] addr);
        case (addr)
            4'd0:    prog_word = 8'h50;
            4'd1:    prog_word = 8'h2E;
            4'd2:    prog_word = 8'h60;
            4'd3:    prog_word = 8'h71;
            4'd14:   prog_word = 8'h01;
            default: prog_word = 8'h00;
        endcase
    endfunction

    // Control ROM: T0/T1 are the shared fetch words for every opcode.
    function automatic logic [CW-1:0] microcode(input logic [5:0] ua);
        logic [CW-1:0] w;
        w = '0;
        case (ua[1:0])
            T0: w[B_MAR_PC] = 1'b1;
            T1: begin
                w[B_IR_LD]  = 1'b1;
                w[B_PC_INC] = 1'b1;
            end
            T2: w[B_MAR_IR] = 1'b1;
            default: begin
                case (ua[5:2])
                    OP_LDA:  w[B_A_MEM]  = 1'b1;
                    OP_ADD:  w[B_A_ADD]  = 1'b1;
                    OP_SUB:  w[B_A_SUB]  = 1'b1;
                    OP_STA:  w[B_MEM_WR] = 1'b1;
                    OP_IN:   w[B_A_IN]   = 1'b1;
                    OP_OUT:  w[B_OUT_LD] = 1'b1;
                    OP_JMP:  w[B_JMP]    = 1'b1;
                    OP_JZ:   w[B_JZ]     = 1'b1;
                    OP_JC:   w[B_JC]     = 1'b1;
                    OP_HLT:  w[B_HLT]    = 1'b1;
                    default: w = '0;
                endcase
            end
        endcase
        microcode = w;
    endfunction

    assign uaddr  = {ir_q[7:4], t_q};
    assign uc     = microcode(uaddr);
    assign mem_rd = mem_q[mar_q];
    assign sum    = {1'b0, a_q} + {1'b0, mem_rd};
    assign diff   = a_q - mem_rd;
    assign OUT    = out_q;

    always_comb begin
        a_d    = a_q;
        pc_d   = pc_q;
        mar_d  = mar_q;
        ir_d   = ir_q;
        z_d    = z_q;
        c_d    = c_q;
        halt_d = halt_q;
        t_d    = t_q;
        out_d  = out_q;
        mem_d  = mem_q;
        if (!halt_q) begin
            t_d = t_q + 2'd1;
            if (uc[B_MAR_PC]) mar_d = pc_q;
            if (uc[B_IR_LD])  ir_d  = mem_rd;
            if (uc[B_PC_INC]) pc_d  = pc_q + 4'd1;
            if (uc[B_MAR_IR]) mar_d = ir_q[3:0];
            if (uc[B_A_MEM]) begin
                a_d = mem_rd;
                z_d = (mem_rd == 8'h00);
            end
            if (uc[B_A_ADD]) begin
                a_d = sum[7:0];
                c_d = sum[8];
                z_d = (sum[7:0] == 8'h00);
            end
            if (uc[B_A_SUB]) begin
                a_d = diff;
                c_d = (a_q >= mem_rd);
                z_d = (diff == 8'h00);
            end
            if (uc[B_MEM_WR]) mem_d[mar_q] = a_q;
            if (uc[B_A_IN]) begin
                a_d = IN;
                z_d = (IN == 8'h00);
            end
            if (uc[B_OUT_LD]) out_d = a_q;
            if (uc[B_JMP] || (uc[B_JZ] && z_q) || (uc[B_JC] && c_q)) pc_d = ir_q[3:0];
            if (uc[B_HLT]) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            halt_q <= 1'b0;
            t_q    <= T0;
            out_q  <= '0;
            for (int unsigned i = 0; i < 16; i++) mem_q[i] <= prog_word(4'(i));
        end else begin
            a_q    <= a_d;
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            ir_q   <= ir_d;
            z_q    <= z_d;
            c_q    <= c_d;
            halt_q <= halt_d;
            t_q    <= t_d;
            out_q  <= out_d;
            for (int unsigned i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_microprogram_iii.sv
// Directed bench for microprogram_iii: checks OUT edge-by-edge against hand-derived
// sequences of the preloaded IN / ADD 14 / OUT / JMP 1 program.
module tb_microprogram_iii;

    logic       clock;
    logic       reset;
    logic [7:0] IN;
    logic [7:0] OUT;

    int total;
    int bad;

    microprogram_iii dut (
        .clock (clock),
        .reset (reset),
        .IN    (IN),
        .OUT   (OUT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Holds reset low for a couple of cycles, then releases it on a falling edge so the
    // next rising edge is edge 1.
    task automatic apply_reset(input logic [7:0] in_val);
        reset = 1'b0;
        IN    = in_val;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        IN    = 8'hA5;
        #1;
        total++;
        if (OUT !== 8'h00) begin
            bad++;
            $display("FAIL reset_async: OUT=%02h expected=00", OUT);
        end
        for (int e = 1; e <= 8; e++) begin
            @(posedge clock);
            #1;
            total++;
            if (OUT !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold edge %0d: OUT=%02h expected=00", e, OUT);
            end
        end
    endtask

    task automatic test_count();
        logic [7:0] exp;
        apply_reset(8'h00);
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock);
            #1;
            exp = (e < 12) ? 8'h00 : (e < 24) ? 8'h01 : (e < 36) ? 8'h02 : 8'h03;
            total++;
            if (OUT !== exp) begin
                bad++;
                $display("FAIL count edge %0d: OUT=%02h expected=%02h", e, OUT, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        apply_reset(8'hFE);
        for (int e = 1; e <= 37; e++) begin
            @(posedge clock);
            #1;
            // FE+1=FF, FF+1=00 with carry, 00+1=01
            exp = (e < 12) ? 8'h00 : (e < 24) ? 8'hFF : (e < 36) ? 8'h00 : 8'h01;
            total++;
            if (OUT !== exp) begin
                bad++;
                $display("FAIL wrap edge %0d: OUT=%02h expected=%02h", e, OUT, exp);
            end
        end
    endtask

    task automatic test_in_change();
        logic [7:0] exp;
        apply_reset(8'h00);
        for (int e = 1; e <= 25; e++) begin
            @(posedge clock);
            #1;
            if (e == 4) IN = 8'h80;
            exp = (e < 12) ? 8'h00 : (e < 24) ? 8'h01 : 8'h02;
            total++;
            if (OUT !== exp) begin
                bad++;
                $display("FAIL in_change edge %0d: OUT=%02h expected=%02h", e, OUT, exp);
            end
        end
        IN = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        apply_reset(8'h00);
        // After edge 26 the machine sits at T2 of the JMP that follows the second OUT.
        repeat (26) @(posedge clock);
        #1;
        total++;
        if (OUT !== 8'h02) begin
            bad++;
            $display("FAIL mid_pre: OUT=%02h expected=02", OUT);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (OUT !== 8'h00) begin
            bad++;
            $display("FAIL mid_async_clear: OUT=%02h expected=00", OUT);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            @(posedge clock);
            #1;
            exp = (e < 12) ? 8'h00 : (e < 24) ? 8'h01 : (e < 36) ? 8'h02 : 8'h03;
            total++;
            if (OUT !== exp) begin
                bad++;
                $display("FAIL mid_rerun edge %0d: OUT=%02h expected=%02h", e, OUT, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        IN    = 8'h00;
        test_reset();
        test_count();
        test_wrap();
        test_in_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microprogram_iii.md
MICROPROGRAM_III -- requirements
Module: microprogram_iii

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-003 The port list SHALL be, one per line:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; 0 clears the machine.
- IN     input  8  input port; sampled only by the IN instruction.
- OUT    output 8  registered output port; written only by the OUT instruction.

Function
REQ-004 The block SHALL be a microprogrammed 8-bit accumulator CPU with these registers:
- A (8b), PC (4b), MAR (4b), IR (8b)
- flags Z and C
- HALT (1b)
- micro-step counter T (2b: T0..T3)
- 16x8 register-based RAM M[0..15]
REQ-005 Instruction format: opcode = IR[7:4], operand address = IR[3:0].
REQ-006 Control signals SHALL come from a 64-word microcode ROM addressed by {IR[7:4], T}; T0 and T1 are shared fetch words.
REQ-007 Every instruction SHALL take exactly 4 clocks, and T SHALL wrap 3->0.
- T0: MAR<=PC.
- T1: IR<=M[MAR]; PC<=PC+1 (mod 16).
- T2: MAR<=IR[3:0].
- T3: execute.
REQ-008 Execute actions at T3:
- 0 NOP: none.
- 1 LDA: A<=M[MAR]; Z updated.
- 2 ADD: {C,A}<=A+M[MAR]; Z updated.
- 3 SUB: A<=A-M[MAR]; C<=1 iff A>=M[MAR] (no borrow); Z updated.
- 4 STA: M[MAR]<=A.
- 5 IN: A<=IN; Z updated.
- 6 OUT: OUT<=A.
- 7 JMP: PC<=IR[3:0].
- 8 JZ: if Z then PC<=IR[3:0].
- 9 JC: if C then PC<=IR[3:0].
- F HLT: HALT<=1.
- A..E: NOP.
REQ-009 Arithmetic SHALL be 8-bit modulo 256, and Z SHALL be 1 iff the 8-bit result is 0.
REQ-010 Instructions not listed as updating Z or C SHALL leave both flags unchanged.
REQ-011 When HALT=1, all registers, RAM and OUT SHALL hold; only reset clears HALT.
REQ-012 The RAM SHALL be reloaded with this program on reset:
- M[0]=0x50 IN
- M[1]=0x2E ADD 14
- M[2]=0x60 OUT
- M[3]=0x71 JMP 1
- M[14]=0x01
- all other words 0x00
REQ-013 A jump at T3 SHALL take effect on the next T0, so a taken jump costs no extra cycle.
REQ-014 An STA to an address containing code SHALL modify the program, i.e. self-modification is permitted.

Reset
REQ-015 While reset=0, the block SHALL immediately and asynchronously clear A, PC, MAR, IR, Z, C, HALT, T and OUT to 0 and restore RAM per REQ-012.
REQ-016 The first rising clock edge after reset returns to 1 SHALL execute T0 of the instruction at address 0.
REQ-017 Assertion of reset in any T state, including while halted, SHALL abort the current instruction with no partial write.

Verification
REQ-018 Reset held low, clock toggling -> OUT=0x00 throughout, with no change on any edge.
REQ-019 Release reset with IN=0x00 -> OUT sequence over clock edges:
- edge 12: OUT=0x01
- edge 24: OUT=0x02
- edge 36: OUT=0x03
- OUT stable between these edges.
REQ-020 IN=0xFE at release -> OUT=0xFF at edge 12, then OUT=0x00 at edge 24 (wrap, carry set).
REQ-021 IN changed from 0x00 to 0x80 after edge 4 -> no effect on the sequence (OUT=0x01 at edge 12), because IN is sampled only at edge 4.
REQ-022 Reset pulsed low at an arbitrary T2 mid-run -> OUT=0x00 immediately on assertion; after release the REQ-019 sequence repeats exactly.
